// File: rtl/axi4_pkg.sv
// AXI4 field widths and burst encodings shared by the DMA blocks.
package axi4_pkg;

  localparam int BURST_BITS = 2;
  localparam int SIZE_BITS  = 3;

  localparam logic [BURST_BITS-1:0] BURST_FIXED = 2'b00;
  localparam logic [BURST_BITS-1:0] BURST_INCR  = 2'b01;
  localparam logic [BURST_BITS-1:0] BURST_WRAP  = 2'b10;

endpackage

// File: rtl/dmac_pkg.sv
// DMA command queue types: the FIFO entry layout and the reserved burst code.
// The entry address width is fixed here and must equal the ADDR_WD used by
// dmac_cmd_queue.
package dmac_pkg;

  localparam int DMAC_ADDR_WD = 32;

  localparam logic [axi4_pkg::BURST_BITS-1:0] BURST_RSVD = 2'b11;

  typedef struct packed {
    logic [DMAC_ADDR_WD-1:0]         src;
    logic [DMAC_ADDR_WD-1:0]         dst;
    logic [axi4_pkg::BURST_BITS-1:0] burst;
    logic [DMAC_ADDR_WD-1:0]         len;
    logic [axi4_pkg::SIZE_BITS-1:0]  size;
  } dmac_cmd_t;

  // Largest legal beat size for a datapath of data_wd bits.
  function automatic logic [axi4_pkg::SIZE_BITS-1:0] max_beat_size(input int data_wd);
    return axi4_pkg::SIZE_BITS'($clog2(data_wd / 8));
  endfunction

endpackage

// File: rtl/dmac_sync_fifo.sv
// Flop-array synchronous FIFO with wrap-bit pointers, full/empty/level
// status and a synchronous clear that empties the queue in one cycle.
module dmac_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr, do_rd;

  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign level_o   = wr_ptr_q - rd_ptr_q;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  assign do_wr = wr_en_i && !full_o;
  assign do_rd = rd_en_i && !empty_o;

  // Pointer advance; clear equalises both pointers and overrides any traffic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // Pointer registers, cleared asynchronously on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents need no reset because empty slots are never shown.
  always_ff @(posedge clk_i) begin
    if (do_wr && !clr_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/dmac_cmd_queue.sv
// Host command intake for the AXI DMA controller: validates commands, buffers
// legal ones in a FIFO, flags rejects with a one-cycle error pulse and a
// saturating reject counter, and supports a one-cycle flush.
// Optional feature: define DMAC_CMD_QUEUE_ALIGN_CHECK_EN to also reject
// commands whose source or destination is not aligned to the beat size.
module dmac_cmd_queue
  import dmac_pkg::*;
#(
  parameter int ADDR_WD = 32,
  parameter int DATA_WD = 32,
  parameter int DEPTH   = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            flush_i,
  input  logic                            in_valid_i,
  input  logic [ADDR_WD-1:0]              in_src_addr_i,
  input  logic [ADDR_WD-1:0]              in_dst_addr_i,
  input  logic [axi4_pkg::BURST_BITS-1:0] in_burst_i,
  input  logic [ADDR_WD-1:0]              in_len_i,
  input  logic [axi4_pkg::SIZE_BITS-1:0]  in_size_i,
  output logic                            in_ready_o,
  output logic                            in_err_o,
  output logic                            cmd_valid_o,
  output logic [ADDR_WD-1:0]              cmd_src_addr_o,
  output logic [ADDR_WD-1:0]              cmd_dst_addr_o,
  output logic [axi4_pkg::BURST_BITS-1:0] cmd_burst_o,
  output logic [ADDR_WD-1:0]              cmd_len_o,
  output logic [axi4_pkg::SIZE_BITS-1:0]  cmd_size_o,
  input  logic                            cmd_ready_i,
  output logic [$clog2(DEPTH):0]          level_o,
  output logic [15:0]                     rej_count_o
);

  localparam logic [axi4_pkg::SIZE_BITS-1:0] MAX_SIZE = max_beat_size(DATA_WD);

  dmac_cmd_t   in_cmd, head_cmd;
  logic        cmd_legal;
  logic        push, pop, reject;
  logic        fifo_full, fifo_empty;
  logic        in_err_q, in_err_d;
  logic [15:0] rej_count_q, rej_count_d;

`ifdef DMAC_CMD_QUEUE_ALIGN_CHECK_EN
  logic [ADDR_WD-1:0] align_mask;
  assign align_mask = (ADDR_WD'(1) << in_size_i) - ADDR_WD'(1);
`endif

  assign in_cmd = '{src:   in_src_addr_i,
                    dst:   in_dst_addr_i,
                    burst: in_burst_i,
                    len:   in_len_i,
                    size:  in_size_i};

  // Command legality check, evaluated on the live host inputs.
  always_comb begin
    cmd_legal = 1'b1;
    if (in_len_i == '0)          cmd_legal = 1'b0;
    if (in_burst_i == BURST_RSVD) cmd_legal = 1'b0;
    if (in_size_i > MAX_SIZE)    cmd_legal = 1'b0;
`ifdef DMAC_CMD_QUEUE_ALIGN_CHECK_EN
    if (|(in_src_addr_i & align_mask) || |(in_dst_addr_i & align_mask)) cmd_legal = 1'b0;
`endif
  end

  assign in_ready_o = !fifo_full && !flush_i;
  assign push       = in_valid_i && in_ready_o;
  assign reject     = push && !cmd_legal;
  assign cmd_valid_o = !fifo_empty;
  assign pop        = cmd_valid_o && cmd_ready_i;

  dmac_sync_fifo #(
    .WIDTH ($bits(dmac_cmd_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (flush_i),
    .wr_en_i   (push && cmd_legal),
    .wr_data_i (in_cmd),
    .rd_en_i   (pop),
    .rd_data_o (head_cmd),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (level_o)
  );

  // Head fields read as zero while nothing is queued.
  assign cmd_src_addr_o = cmd_valid_o ? head_cmd.src   : '0;
  assign cmd_dst_addr_o = cmd_valid_o ? head_cmd.dst   : '0;
  assign cmd_burst_o    = cmd_valid_o ? head_cmd.burst : '0;
  assign cmd_len_o      = cmd_valid_o ? head_cmd.len   : '0;
  assign cmd_size_o     = cmd_valid_o ? head_cmd.size  : '0;

  // Next error pulse and saturating reject count.
  always_comb begin
    in_err_d    = reject;
    rej_count_d = rej_count_q;
    if (reject && (rej_count_q != 16'hFFFF)) begin
      rej_count_d = rej_count_q + 16'd1;
    end
  end

  // Error and counter registers; flush leaves the counter alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_err_q    <= 1'b0;
      rej_count_q <= '0;
    end else begin
      in_err_q    <= in_err_d;
      rej_count_q <= rej_count_d;
    end
  end

  assign in_err_o    = in_err_q;
  assign rej_count_o = rej_count_q;

endmodule

// File: tb/tb_dmac_cmd_queue.sv
// Self-checking bench for dmac_cmd_queue: a vector table for single-cycle
// behaviour, hand-written sequences for fill, flush, alignment and reset,
// and a scoreboard that compares every popped head against the pushed order.
module tb_dmac_cmd_queue;
  import dmac_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        in_valid_i;
  logic [31:0] in_src_addr_i;
  logic [31:0] in_dst_addr_i;
  logic [1:0]  in_burst_i;
  logic [31:0] in_len_i;
  logic [2:0]  in_size_i;
  logic        in_ready_o;
  logic        in_err_o;
  logic        cmd_valid_o;
  logic [31:0] cmd_src_addr_o;
  logic [31:0] cmd_dst_addr_o;
  logic [1:0]  cmd_burst_o;
  logic [31:0] cmd_len_o;
  logic [2:0]  cmd_size_o;
  logic        cmd_ready_i;
  logic [2:0]  level_o;
  logic [15:0] rej_count_o;

  int checks = 0;
  int errors = 0;
  int popCount = 0;
  int expRej = 0;
  dmac_cmd_t sbQ[$];

  typedef struct {
    bit        valid;
    dmac_cmd_t cmd;
    bit        ready;
    int        expLevel;
    bit        expValid;
    bit        expErr;
    bit        expRdy;
    int        expRejCnt;
  } vec_t;

  vec_t vecs[13];

  dmac_cmd_queue #(.ADDR_WD(32), .DATA_WD(32), .DEPTH(4)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .in_valid_i     (in_valid_i),
    .in_src_addr_i  (in_src_addr_i),
    .in_dst_addr_i  (in_dst_addr_i),
    .in_burst_i     (in_burst_i),
    .in_len_i       (in_len_i),
    .in_size_i      (in_size_i),
    .in_ready_o     (in_ready_o),
    .in_err_o       (in_err_o),
    .cmd_valid_o    (cmd_valid_o),
    .cmd_src_addr_o (cmd_src_addr_o),
    .cmd_dst_addr_o (cmd_dst_addr_o),
    .cmd_burst_o    (cmd_burst_o),
    .cmd_len_o      (cmd_len_o),
    .cmd_size_o     (cmd_size_o),
    .cmd_ready_i    (cmd_ready_i),
    .level_o        (level_o),
    .rej_count_o    (rej_count_o)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk_i = ~clk_i;

  function automatic dmac_cmd_t mk(input logic [31:0] s, input logic [31:0] d,
                                   input logic [1:0] b, input logic [31:0] l,
                                   input logic [2:0] z);
    dmac_cmd_t c;
    c.src = s; c.dst = d; c.burst = b; c.len = l; c.size = z;
    return c;
  endfunction

  function automatic vec_t mkVec(input bit v, input dmac_cmd_t c, input bit r,
                                 input int lvl, input bit vld, input bit err,
                                 input bit rdy, input int rej);
    vec_t x;
    x.valid = v; x.cmd = c; x.ready = r; x.expLevel = lvl; x.expValid = vld;
    x.expErr = err; x.expRdy = rdy; x.expRejCnt = rej;
    return x;
  endfunction

  // Independent legality model: 32-bit datapath allows beat sizes up to 2.
  function automatic bit tbLegal(input dmac_cmd_t c);
    if (c.len == 32'd0) return 1'b0;
    if (c.burst == 2'b11) return 1'b0;
    if (c.size > 3'd2) return 1'b0;
`ifdef DMAC_CMD_QUEUE_ALIGN_CHECK_EN
    if ((c.src % (32'd1 << c.size)) != 32'd0) return 1'b0;
    if ((c.dst % (32'd1 << c.size)) != 32'd0) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic dmac_cmd_t curCmd();
    return mk(in_src_addr_i, in_dst_addr_i, in_burst_i, in_len_i, in_size_i);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit v, input dmac_cmd_t c, input bit r, input bit f);
    in_valid_i    = v;
    in_src_addr_i = c.src;
    in_dst_addr_i = c.dst;
    in_burst_i    = c.burst;
    in_len_i      = c.len;
    in_size_i     = c.size;
    cmd_ready_i   = r;
    flush_i       = f;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Mid-cycle monitor: scores pops against the expected order and records
  // accepted pushes into the expected queue or the reject model.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (cmd_valid_o && cmd_ready_i) begin
        if (sbQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL pop_unexpected actual=src 0x%0h required=no pop", cmd_src_addr_o);
        end else begin
          dmac_cmd_t e;
          e = sbQ.pop_front();
          checkOutput("head_src", cmd_src_addr_o, e.src);
          checkOutput("head_dst", cmd_dst_addr_o, e.dst);
          checkOutput("head_burst", cmd_burst_o, e.burst);
          checkOutput("head_len", cmd_len_o, e.len);
          checkOutput("head_size", cmd_size_o, e.size);
          popCount++;
        end
      end
      if (in_valid_i && in_ready_o) begin
        if (tbLegal(curCmd())) sbQ.push_back(curCmd());
        else if (expRej < 65535) expRej++;
      end
    end
  end

  initial begin
    dmac_cmd_t z, cmdA, alignCmd;
    int pops0;
    z = mk(0, 0, 0, 0, 0);
    cmdA = mk(32'h1000, 32'h2000, 2'b01, 32'd64, 3'd2);
    alignCmd = mk(32'h1002, 32'h2000, 2'b01, 32'd16, 3'd2);

    vecs[0]  = mkVec(1, cmdA, 0, 1, 1, 0, 1, 0);
    vecs[1]  = mkVec(0, z, 1, 0, 0, 0, 1, 0);
    vecs[2]  = mkVec(1, mk(32'h1100, 32'h2100, 2'b01, 32'd0, 3'd2), 0, 0, 0, 1, 1, 1);
    vecs[3]  = mkVec(1, mk(32'h1200, 32'h2200, 2'b11, 32'd32, 3'd2), 0, 0, 0, 1, 1, 2);
    vecs[4]  = mkVec(1, mk(32'h1300, 32'h2300, 2'b01, 32'd32, 3'd3), 0, 0, 0, 1, 1, 3);
    vecs[5]  = mkVec(0, z, 0, 0, 0, 0, 1, 3);
    vecs[6]  = mkVec(1, mk(32'h3000, 32'h4000, 2'b00, 32'd16, 3'd0), 0, 1, 1, 0, 1, 3);
    vecs[7]  = mkVec(1, mk(32'h3040, 32'h4080, 2'b01, 32'd32, 3'd1), 0, 2, 1, 0, 1, 3);
    vecs[8]  = mkVec(1, mk(32'h3080, 32'h4100, 2'b10, 32'd48, 3'd2), 1, 2, 1, 0, 1, 3);
    vecs[9]  = mkVec(1, mk(32'h30C0, 32'h4180, 2'b00, 32'd64, 3'd0), 1, 2, 1, 0, 1, 3);
    vecs[10] = mkVec(1, mk(32'h3100, 32'h4200, 2'b01, 32'd80, 3'd1), 1, 2, 1, 0, 1, 3);
    vecs[11] = mkVec(0, z, 1, 1, 1, 0, 1, 3);
    vecs[12] = mkVec(0, z, 1, 0, 0, 0, 1, 3);

    rst_ni = 1'b0;
    applyStimulus(0, z, 0, 0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    #1;

    checkOutput("reset_in_ready", in_ready_o, 1);
    checkOutput("reset_in_err", in_err_o, 0);
    checkOutput("reset_cmd_valid", cmd_valid_o, 0);
    checkOutput("reset_level", level_o, 0);
    checkOutput("reset_rej_count", rej_count_o, 0);
    checkOutput("reset_cmd_src", cmd_src_addr_o, 0);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].cmd, vecs[i].ready, 0);
      tick();
      checkOutput($sformatf("vec%0d_level", i), level_o, vecs[i].expLevel);
      checkOutput($sformatf("vec%0d_cmd_valid", i), cmd_valid_o, vecs[i].expValid);
      checkOutput($sformatf("vec%0d_in_err", i), in_err_o, vecs[i].expErr);
      checkOutput($sformatf("vec%0d_in_ready", i), in_ready_o, vecs[i].expRdy);
      checkOutput($sformatf("vec%0d_rej_count", i), rej_count_o, vecs[i].expRejCnt);
    end
    checkOutput("table_pops", popCount, 6);
    checkOutput("table_sb_empty", sbQ.size(), 0);

    // Fill to capacity, hold a fifth command until space appears.
    pops0 = popCount;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, mk(32'h5000 + 32'(i) * 32'h100, 32'h6000 + 32'(i) * 32'h100, 2'b01, 32'd8 * 32'(i + 1), 3'd2), 0, 0);
      tick();
    end
    checkOutput("full_level", level_o, 4);
    checkOutput("full_in_ready", in_ready_o, 0);
    applyStimulus(1, mk(32'h5400, 32'h6400, 2'b01, 32'd40, 3'd2), 0, 0);
    tick();
    tick();
    checkOutput("full_hold_level", level_o, 4);
    checkOutput("full_hold_in_ready", in_ready_o, 0);
    cmd_ready_i = 1'b1;
    tick();
    checkOutput("full_pop_only_level", level_o, 3);
    cmd_ready_i = 1'b0;
    tick();
    checkOutput("full_refill_level", level_o, 4);
    applyStimulus(0, z, 1, 0);
    for (int k = 0; k < 10 && level_o != 3'd0; k++) tick();
    checkOutput("full_drain_level", level_o, 0);
    checkOutput("full_drain_pops", popCount - pops0, 5);
    checkOutput("full_sb_empty", sbQ.size(), 0);

    // Flush with three queued and the controller taking the head.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, mk(32'h7000 + 32'(i) * 32'h10, 32'h8000, 2'b01, 32'd4, 3'd2), 0, 0);
      tick();
    end
    checkOutput("flush_pre_level", level_o, 3);
    pops0 = popCount;
    applyStimulus(1, mk(32'h9000, 32'h9100, 2'b01, 32'd4, 3'd2), 1, 1);
    #1;
    checkOutput("flush_in_ready", in_ready_o, 0);
    @(posedge clk_i);
    #1;
    sbQ.delete();
    checkOutput("flush_cmd_valid", cmd_valid_o, 0);
    checkOutput("flush_level", level_o, 0);
    checkOutput("flush_pops", popCount - pops0, 1);
    applyStimulus(0, z, 0, 0);
    #1;
    checkOutput("flush_release_in_ready", in_ready_o, 1);
    checkOutput("flush_rej_kept", rej_count_o, 3);
    tick();
    checkOutput("flush_no_write_level", level_o, 0);

    // Misaligned source address.
    applyStimulus(1, alignCmd, 0, 0);
    tick();
`ifdef DMAC_CMD_QUEUE_ALIGN_CHECK_EN
    checkOutput("align_in_err", in_err_o, 1);
    checkOutput("align_level", level_o, 0);
`else
    checkOutput("align_in_err", in_err_o, 0);
    checkOutput("align_level", level_o, 1);
    checkOutput("align_cmd_valid", cmd_valid_o, 1);
`endif
    applyStimulus(0, z, 1, 0);
    tick();
    checkOutput("align_drain_level", level_o, 0);
    checkOutput("align_rej_count", rej_count_o, expRej);
    checkOutput("align_sb_empty", sbQ.size(), 0);

    // Asynchronous reset with entries queued.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, mk(32'hA000 + 32'(i) * 32'h10, 32'hB000, 2'b01, 32'd4, 3'd2), 0, 0);
      tick();
    end
    checkOutput("rst_pre_level", level_o, 3);
    applyStimulus(0, z, 0, 0);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("rst_level", level_o, 0);
    checkOutput("rst_cmd_valid", cmd_valid_o, 0);
    checkOutput("rst_in_ready", in_ready_o, 1);
    checkOutput("rst_in_err", in_err_o, 0);
    checkOutput("rst_rej_count", rej_count_o, 0);
    checkOutput("rst_cmd_src", cmd_src_addr_o, 0);
    sbQ.delete();
    expRej = 0;
    #3;
    rst_ni = 1'b1;
    tick();

    // Recovery after reset.
    applyStimulus(1, cmdA, 0, 0);
    tick();
    checkOutput("recover_cmd_valid", cmd_valid_o, 1);
    applyStimulus(0, z, 1, 0);
    tick();
    checkOutput("recover_level", level_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
